// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier control path.
// Holds the sequencer state encoding and the default operand width,
// which the sequencer and the register unit both use.
package mult_pkg;

  // Default operand width: the number of add/shift iterations.
  localparam int MULT_WIDTH = 8;

  // Sequencer states. Five states need three bits; encodings 5..7 are
  // unused and steer back to IDLE.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLRXA = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    HALT  = 3'd4
  } mult_state_t;

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter for the shift-add multiplier.
// Counts completed shift iterations and flags the last one (WIDTH-1).
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   clear  - synchronous clear to zero
//   en     - advance by one (holds once the last iteration is reached)
//   last   - high while the count equals WIDTH-1
module mult_iter_counter
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic last
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt_reg;

  assign last = (cnt_reg == CNT_W'(WIDTH - 1));

  // Saturate at WIDTH-1: the final shift advances the FSM to HALT, so the
  // count never needs to reach WIDTH and must not wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (en && !last) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mult_sequencer.sv
// Control FSM for the 8-bit signed shift-add multiplier.
// Sequences clear/load of X:A, WIDTH add/shift iterations over B and a
// final subtract on the sign-bit iteration, leaving the product in A:B.
// Ports:
//   Clk          - clock, rising edge
//   Reset        - asynchronous active-low reset; forces all outputs low
//   Run          - start request (level)
//   ClearA_LoadB - in IDLE: clear X/A and load B
//   M            - current LSB of register B
//   LoadB        - parallel load of B
//   ClearXA      - synchronous clear of X and A
//   LoadXA       - load adder result into X:A
//   Sub          - adder subtracts (A - S) when high
//   Shift_En     - arithmetic right shift of X:A:B
//   Busy         - operation in progress
//   Done         - product valid (held in HALT)
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic LoadB,
  output logic ClearXA,
  output logic LoadXA,
  output logic Sub,
  output logic Shift_En,
  output logic Busy,
  output logic Done
);

  mult_state_t state_reg;
  mult_state_t state_next;
  logic        cnt_clear;
  logic        cnt_en;
  logic        last_iter;

  mult_iter_counter #(
    .WIDTH (WIDTH)
  ) u_iter_counter (
    .clk   (Clk),
    .rst_n (Reset),
    .clear (cnt_clear),
    .en    (cnt_en),
    .last  (last_iter)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Outputs decode from the registered state. The IDLE load strobe also
  // follows ClearA_LoadB, so the whole decode is gated by Reset to keep
  // every output low for as long as reset is held.
  always_comb begin
    state_next = state_reg;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    LoadB      = 1'b0;
    ClearXA    = 1'b0;
    LoadXA     = 1'b0;
    Sub        = 1'b0;
    Shift_En   = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    if (Reset) begin
      case (state_reg)
        IDLE: begin
          if (Run) begin
            // Run has priority over a simultaneous load request.
            state_next = CLRXA;
          end else if (ClearA_LoadB) begin
            LoadB   = 1'b1;
            ClearXA = 1'b1;
          end
        end
        CLRXA: begin
          Busy       = 1'b1;
          ClearXA    = 1'b1;
          cnt_clear  = 1'b1;
          state_next = ADD;
        end
        ADD: begin
          Busy   = 1'b1;
          LoadXA = M;
          // The MSB of a two's-complement multiplier carries negative
          // weight, so its partial product is subtracted.
          Sub        = M & last_iter;
          state_next = SHIFT;
        end
        SHIFT: begin
          Busy       = 1'b1;
          Shift_En   = 1'b1;
          cnt_en     = 1'b1;
          state_next = last_iter ? HALT : ADD;
        end
        HALT: begin
          Done = 1'b1;
          // Leaving HALT needs Run low, so a held Run cannot restart.
          state_next = Run ? HALT : IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer. A behavioural X:A:B datapath
// driven by the DUT's controls supplies M and yields the product, which
// is compared against plain signed multiplication. Stimulus tasks push the
// expected per-cycle control pattern and products into queues; a monitor
// pops and compares them.
module tb_mult_sequencer;

  localparam int W = 8;

  localparam logic [6:0] V_LOADB  = 7'b1000000;
  localparam logic [6:0] V_CLRXA  = 7'b0100000;
  localparam logic [6:0] V_LOADXA = 7'b0010000;
  localparam logic [6:0] V_SUB    = 7'b0001000;
  localparam logic [6:0] V_SHIFT  = 7'b0000100;
  localparam logic [6:0] V_BUSY   = 7'b0000010;
  localparam logic [6:0] V_DONE   = 7'b0000001;

  typedef struct {
    int         cyc;
    logic [6:0] vec;
  } vexp_t;

  typedef struct {
    int          cyc;
    logic [15:0] prod;
  } pexp_t;

  logic Clk = 1'b0;
  logic Reset;
  logic Run;
  logic ClearA_LoadB;
  logic M;
  logic LoadB, ClearXA, LoadXA, Sub, Shift_En, Busy, Done;

  mult_sequencer #(.WIDTH(W)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .M            (M),
    .LoadB        (LoadB),
    .ClearXA      (ClearXA),
    .LoadXA       (LoadXA),
    .Sub          (Sub),
    .Shift_En     (Shift_En),
    .Busy         (Busy),
    .Done         (Done)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Behavioural register unit: X, A, B and the 9-bit adder.
  logic [7:0] sw = 8'h00;     // switch value loaded into B
  logic [7:0] s_val = 8'h00;  // multiplicand S
  logic       x_reg = 1'b0;
  logic [7:0] a_reg = 8'h00;
  logic [7:0] b_reg = 8'h00;
  logic [8:0] sum9;

  assign M    = b_reg[0];
  assign sum9 = Sub ? ({a_reg[7], a_reg} - {s_val[7], s_val})
                    : ({a_reg[7], a_reg} + {s_val[7], s_val});

  always @(posedge Clk) begin
    if (LoadB) b_reg <= sw;
    if (ClearXA) begin
      x_reg <= 1'b0;
      a_reg <= 8'h00;
    end else if (LoadXA) begin
      x_reg <= sum9[8];
      a_reg <= sum9[7:0];
    end
    if (Shift_En) begin
      a_reg <= {x_reg, a_reg[7:1]};
      b_reg <= {a_reg[0], b_reg[7:1]};
    end
  end

  vexp_t vq[$];
  pexp_t pq[$];
  logic [7:0] b_exp = 8'h00;
  bit finish_req = 1'b0;

  task automatic push_vec(input int c, input logic [6:0] v);
    vexp_t e;
    e.cyc = c;
    e.vec = v;
    vq.push_back(e);
  endtask

  // Expected controls for an operation whose Run is sampled at the end of
  // cycle c; cycles beyond 'upto' are not scheduled.
  task automatic sched(input int c, input int upto, input int nd);
    push_vec(c, 7'b0);
    if (upto >= 1) push_vec(c + 1, V_CLRXA | V_BUSY);
    for (int i = 0; i < W; i++) begin
      int n;
      logic [6:0] v;
      n = 2 + 2 * i;
      v = V_BUSY;
      if (b_exp[i]) v = v | V_LOADXA | ((i == W - 1) ? V_SUB : 7'b0);
      if (n <= upto) push_vec(c + n, v);
      if (n + 1 <= upto) push_vec(c + n + 1, V_SHIFT | V_BUSY);
    end
    for (int k = 0; k < nd; k++) begin
      if (18 + k <= upto) push_vec(c + 18 + k, V_DONE);
    end
  endtask

  // All stimulus tasks start and end just after a falling edge.
  task automatic load_b(input logic [7:0] bval, input int n);
    int c;
    c = cyc;
    sw = bval;
    s_val = 8'($urandom);
    Run = 1'b0;
    ClearA_LoadB = 1'b1;
    for (int k = 0; k < n; k++) push_vec(c + k, V_LOADB | V_CLRXA);
    $display("load  B=%02h S=%02h for %0d cycles", bval, s_val, n);
    for (int k = 0; k < n; k++) @(negedge Clk);
    ClearA_LoadB = 1'b0;
    b_exp = bval;
  endtask

  // hold = 0: Run for one cycle; hold > 0: Run held through 'hold' HALT cycles.
  task automatic run_op(input int hold, input bit both, input bit toggle);
    int c;
    int nd;
    pexp_t pe;
    logic signed [15:0] p;
    c = cyc;
    nd = (hold == 0) ? 1 : hold;
    p = $signed({{8{s_val[7]}}, s_val}) * $signed({{8{b_exp[7]}}, b_exp});
    Run = 1'b1;
    ClearA_LoadB = both;
    sched(c, 17 + nd, nd);
    pe.cyc = c + 18;
    pe.prod = p;
    pq.push_back(pe);
    $display("run   S=%02h B=%02h hold=%0d both=%0d toggle=%0d expect=%04h",
             s_val, b_exp, hold, both, toggle, p);
    for (int n = 1; n <= 17 + nd; n++) begin
      @(negedge Clk);
      if (hold == 0 && n == 1) Run = 1'b0;
      if (hold > 0 && n == 17 + hold) Run = 1'b0;
      ClearA_LoadB = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    @(negedge Clk);
    ClearA_LoadB = 1'b0;
    b_exp = p[7:0];
  endtask

  // Start an operation and assert reset in its third ADD cycle.
  task automatic reset_mid_op();
    int c;
    c = cyc;
    Run = 1'b1;
    sched(c, 5, 1);
    $display("reset during third ADD cycle");
    for (int n = 1; n <= 5; n++) begin
      @(negedge Clk);
      if (n == 1) Run = 1'b0;
    end
    @(negedge Clk);
    Reset = 1'b0;
    push_vec(c + 6, 7'b0);
    @(negedge Clk);
    push_vec(c + 7, 7'b0);
    @(negedge Clk);
    Reset = 1'b1;
    push_vec(c + 8, 7'b0);
  endtask

  initial begin
    Reset = 1'b0;
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    @(negedge Clk);
    push_vec(cyc, 7'b0);
    ClearA_LoadB = 1'b1;   // outputs must stay low while reset is held
    @(negedge Clk);
    push_vec(cyc, 7'b0);
    ClearA_LoadB = 1'b0;
    Reset = 1'b1;
    @(negedge Clk);

    load_b(8'h05, 3);
    run_op(0, 1'b0, 1'b0);
    load_b(8'h80, 1);
    run_op(0, 1'b0, 1'b0);
    load_b(8'($urandom), 2);
    run_op(10, 1'b0, 1'b0);
    run_op(0, 1'b0, 1'b0);   // Run raised again right after leaving HALT
    load_b(8'($urandom), 1);
    run_op(0, 1'b1, 1'b1);
    load_b(8'($urandom), 1);
    reset_mid_op();
    @(negedge Clk);
    load_b(8'($urandom), 1);
    run_op(0, 1'b0, 1'b0);
    for (int t = 0; t < 6; t++) begin
      load_b(8'($urandom), 1 + int'($urandom_range(0, 2)));
      run_op(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    repeat (3) @(negedge Clk);
    finish_req = 1'b1;
  end

  // Monitor: sole owner of the check/error counters.
  int checks = 0;
  int errors = 0;
  logic done_prev = 1'b0;

  initial begin
    vexp_t e;
    pexp_t pe;
    logic [6:0] vec;
    forever begin
      @(negedge Clk);
      #2;
      vec = {LoadB, ClearXA, LoadXA, Sub, Shift_En, Busy, Done};
      while (vq.size() > 0 && vq[0].cyc <= cyc) begin
        e = vq.pop_front();
        checks++;
        if (e.cyc < cyc) begin
          errors++;
          $display("FAIL ctl_missed cyc=%0d expected entry for cyc %0d", cyc, e.cyc);
        end else if (vec !== e.vec) begin
          errors++;
          $display("FAIL ctl cyc=%0d got=%b expected=%b (LoadB,ClearXA,LoadXA,Sub,Shift_En,Busy,Done)",
                   cyc, vec, e.vec);
        end
      end
      if (Done === 1'b1 && done_prev !== 1'b1) begin
        checks++;
        if (pq.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected cyc=%0d got Done=1 expected no product", cyc);
        end else begin
          pe = pq.pop_front();
          if (pe.cyc != cyc || {a_reg, b_reg} !== pe.prod) begin
            errors++;
            $display("FAIL product cyc=%0d got=%04h expected=%04h at cyc %0d",
                     cyc, {a_reg, b_reg}, pe.prod, pe.cyc);
          end else begin
            $display("done  product=%04h at cyc %0d", pe.prod, cyc);
          end
        end
      end
      done_prev = Done;
      if (finish_req) begin
        checks++;
        if (vq.size() != 0 || pq.size() != 0) begin
          errors++;
          $display("FAIL drain got=%0d/%0d pending expected=0/0", vq.size(), pq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got=no finish expected=finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
